// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a raw asynchronous input, debounces it into
// a clean level, and produces one-cycle rise/fall pulses plus a saturating
// count of rising events.
// Optional feature macro: INPUT_DEBOUNCER_GLITCH_CNT_EN adds glitch_cnt_o,
// a saturating count of pending mismatches that die out before threshold.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_i,
    input  logic             clr_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] event_cnt_o
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    ,
    output logic [7:0]       glitch_cnt_o
`endif
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVT_MAX = '1;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       event_cnt_q, event_cnt_d;
    state_e                 state_q, state_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchronizer: shift raw_i through the chain; the last stage is "sync".
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    // Debounce counter and FSM next state: count consecutive mismatches,
    // flip the level at threshold, abort silently if the mismatch vanishes.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips an assignment infers a latch.
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        state_d  = state_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync == level_q) begin
            db_cnt_d = '0;
            state_d  = ST_STABLE;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = sync;
            db_cnt_d = '0;
            state_d  = ST_STABLE;
            rise_d   = sync;
            fall_d   = ~sync;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
            state_d  = ST_PENDING;
        end
    end

    // Rising-event counter: saturating; clear wins but a coincident rise counts.
    always_comb begin
        event_cnt_d = event_cnt_q;
        if (clr_i) begin
            event_cnt_d = rise_d ? CNT_W'(1) : '0;
        end else if (rise_d && (event_cnt_q != EVT_MAX)) begin
            event_cnt_d = event_cnt_q + CNT_W'(1);
        end
    end

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic       glitch_abort;
    logic [7:0] glitch_cnt_q, glitch_cnt_d;

    // A pending mismatch that disappears before threshold is a rejected glitch.
    assign glitch_abort = (state_q == ST_PENDING) && (sync == level_q);

    // Glitch counter: same saturation and clear priority as the event counter.
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (clr_i) begin
            glitch_cnt_d = glitch_abort ? 8'd1 : 8'd0;
        end else if (glitch_abort && (glitch_cnt_q != 8'hFF)) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end
    end

    // Glitch counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_cnt_q <= 8'd0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt_o = glitch_cnt_q;
`endif

    // All debouncer state, including the FSM, in one clocked block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the synchronizer chain is reset too, so a stale high
            // sample cannot leak through right after reset release.
            sync_q      <= '0;
            db_cnt_q    <= '0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            event_cnt_q <= '0;
            state_q     <= ST_STABLE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its neighbours, as real hardware does.
            sync_q      <= sync_d;
            db_cnt_q    <= db_cnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            event_cnt_q <= event_cnt_d;
            state_q     <= state_d;
        end
    end

    assign level_o     = level_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign event_cnt_o = event_cnt_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with default parameters.
// Expected rise/fall pulses are queued when stimulus is driven and are
// compared (cycle, direction, event count) when the DUT emits them.
module tb_input_debouncer;

    localparam int LAT = 6;  // 2 sync stages + 4 debounce cycles

    logic       clk;
    logic       reset;
    logic       raw_i;
    logic       clr_i;
    logic       level_o;
    logic       rise_o;
    logic       fall_o;
    logic [7:0] event_cnt_o;
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_o;
`endif

    input_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_i      (raw_i),
        .clr_i      (clr_i),
        .level_o    (level_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .event_cnt_o(event_cnt_o)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        ,
        .glitch_cnt_o(glitch_cnt_o)
`endif
    );

    typedef struct {
        bit         is_rise;
        int         cyc;
        logic [7:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  exp_cnt = 0;
    int  exp_glitch = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        ev_t e;
        if (rise_o === 1'b1 || fall_o === 1'b1) begin
            n_cmp++;
            if (rise_o === 1'b1 && fall_o === 1'b1) begin
                n_err++;
                $display("FAIL both_pulses cyc=%0d rise=1 fall=1 required not both", cyc);
            end else if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse cyc=%0d rise=%0b fall=%0b required none", cyc, rise_o, fall_o);
            end else begin
                e = exp_q.pop_front();
                if (e.is_rise !== rise_o || e.cyc != cyc || e.cnt !== event_cnt_o) begin
                    n_err++;
                    $display("FAIL pulse got rise=%0b cyc=%0d cnt=%0d required rise=%0b cyc=%0d cnt=%0d",
                             rise_o, cyc, event_cnt_o, e.is_rise, e.cyc, e.cnt);
                end
            end
        end
    end

    // Stimulus helper: clean pulse of hi cycles high then lo cycles low,
    // starting at the current falling edge; queues the expected pulses.
    task automatic drive_pulse(input int hi, input int lo);
        int n;
        raw_i = 1'b1;
        n = cyc;
        exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        exp_q.push_back('{1'b1, n + LAT, 8'(exp_cnt)});
        exp_q.push_back('{1'b0, n + hi + LAT, 8'(exp_cnt)});
        repeat (hi) @(negedge clk);
        raw_i = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        raw_i = 1'b1;
        clr_i = 1'b0;
        #1;
        n_cmp++;
        if ({level_o, rise_o, fall_o, event_cnt_o} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_async got lvl=%0b r=%0b f=%0b cnt=%0d required all 0", level_o, rise_o, fall_o, event_cnt_o);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({level_o, rise_o, fall_o, event_cnt_o} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_hold got lvl=%0b r=%0b f=%0b cnt=%0d required all 0", level_o, rise_o, fall_o, event_cnt_o);
        end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt_o !== 8'd0) begin
            n_err++;
            $display("FAIL reset_glitch got %0d required 0", glitch_cnt_o);
        end
`endif
        reset = 1'b1;
        n = cyc;
        exp_cnt = 1;
        exp_q.push_back('{1'b1, n + LAT, 8'd1});
        repeat (LAT - 1) @(negedge clk);
        n_cmp++;
        if (level_o !== 1'b0) begin
            n_err++;
            $display("FAIL release_early got level=%0b required 0", level_o);
        end
        @(negedge clk);
        n_cmp++;
        if (level_o !== 1'b1) begin
            n_err++;
            $display("FAIL release_level got level=%0b required 1", level_o);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || event_cnt_o !== 8'd1) begin
            n_err++;
            $display("FAIL release_done got pending=%0d cnt=%0d required 0 and 1", exp_q.size(), event_cnt_o);
        end
    endtask

    task automatic test_fall();
        int n;
        raw_i = 1'b0;
        n = cyc;
        exp_q.push_back('{1'b0, n + LAT, 8'(exp_cnt)});
        repeat (10) @(negedge clk);
        n_cmp++;
        if (level_o !== 1'b0 || event_cnt_o !== 8'(exp_cnt) || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL fall got lvl=%0b cnt=%0d pending=%0d required 0 %0d 0", level_o, event_cnt_o, exp_q.size(), exp_cnt);
        end
    endtask

    task automatic test_glitch();
        raw_i = 1'b1;
        repeat (3) @(negedge clk);
        raw_i = 1'b0;
        exp_glitch++;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (level_o !== 1'b0 || event_cnt_o !== 8'(exp_cnt)) begin
            n_err++;
            $display("FAIL glitch3 got lvl=%0b cnt=%0d required 0 %0d", level_o, event_cnt_o, exp_cnt);
        end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt_o !== 8'(exp_glitch)) begin
            n_err++;
            $display("FAIL glitch_cnt got %0d required %0d", glitch_cnt_o, exp_glitch);
        end
`endif
        drive_pulse(4, 10);
        n_cmp++;
        if (level_o !== 1'b0 || event_cnt_o !== 8'(exp_cnt) || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pulse4 got lvl=%0b cnt=%0d pending=%0d required 0 %0d 0", level_o, event_cnt_o, exp_q.size(), exp_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 260; k++) drive_pulse(10, 10);
        n_cmp++;
        if (event_cnt_o !== 8'd255 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL saturate got cnt=%0d pending=%0d required 255 0", event_cnt_o, exp_q.size());
        end
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        exp_cnt = 0;
        exp_glitch = 0;
        n_cmp++;
        if (event_cnt_o !== 8'd0) begin
            n_err++;
            $display("FAIL clear got cnt=%0d required 0", event_cnt_o);
        end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt_o !== 8'd0) begin
            n_err++;
            $display("FAIL clear_glitch got %0d required 0", glitch_cnt_o);
        end
`endif
    endtask

    task automatic test_clr_coincident();
        int n;
        for (int k = 0; k < 7; k++) drive_pulse(10, 10);
        n_cmp++;
        if (event_cnt_o !== 8'd7) begin
            n_err++;
            $display("FAIL pre_clr got cnt=%0d required 7", event_cnt_o);
        end
        raw_i = 1'b1;
        n = cyc;
        exp_cnt = 1;
        exp_q.push_back('{1'b1, n + LAT, 8'd1});
        exp_q.push_back('{1'b0, n + 10 + LAT, 8'd1});
        repeat (LAT - 1) @(negedge clk);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        repeat (4) @(negedge clk);
        raw_i = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (event_cnt_o !== 8'd1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL clr_rise got cnt=%0d pending=%0d required 1 0", event_cnt_o, exp_q.size());
        end
    endtask

    task automatic test_reset_pending();
        int n;
        raw_i = 1'b1;
        n = cyc;
        exp_cnt++;
        exp_q.push_back('{1'b1, n + LAT, 8'(exp_cnt)});
        repeat (10) @(negedge clk);
        n_cmp++;
        if (level_o !== 1'b1 || event_cnt_o !== 8'(exp_cnt)) begin
            n_err++;
            $display("FAIL pre_pending got lvl=%0b cnt=%0d required 1 %0d", level_o, event_cnt_o, exp_cnt);
        end
        raw_i = 1'b0;
        repeat (4) @(negedge clk);  // debounce counter now at 2
        #1 reset = 1'b0;
        exp_cnt = 0;
        exp_glitch = 0;
        #1;
        n_cmp++;
        if ({level_o, rise_o, fall_o, event_cnt_o} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_pending got lvl=%0b r=%0b f=%0b cnt=%0d required all 0", level_o, rise_o, fall_o, event_cnt_o);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (level_o !== 1'b0 || event_cnt_o !== 8'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL after_reset got lvl=%0b cnt=%0d pending=%0d required 0 0 0", level_o, event_cnt_o, exp_q.size());
        end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt_o !== 8'd0) begin
            n_err++;
            $display("FAIL after_reset_glitch got %0d required 0", glitch_cnt_o);
        end
`endif
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout cyc=%0d required completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fall();
        test_glitch();
        test_saturation();
        test_clr_coincident();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions a raw, asynchronous, bouncy input (pushbutton or external strobe) into a clean, synchronous level. The result drives the d_i input of the flop stage directly downstream. Also produces single-cycle rise and fall pulses and a saturating count of rising events for software or debug.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on raw_i; minimum 2.
DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized input must differ from level_o before level_o changes; minimum 1.
CNT_W, 8, width of event_cnt_o.

Ports:
clk  input  1  single system clock; all state on its rising edge.
reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of clk.
raw_i  input  1  raw asynchronous input; no timing relationship to clk.
clr_i  input  1  synchronous clear of event_cnt_o (and glitch_cnt_o when present).
level_o  output  1  debounced, synchronized level; feeds the downstream d_i.
rise_o  output  1  one-cycle pulse on a 0->1 change of level_o.
fall_o  output  1  one-cycle pulse on a 1->0 change of level_o.
event_cnt_o  output  CNT_W  saturating count of rise_o pulses.

Behaviour:
- Reset (reset=0): all synchronizer flops, debounce counter, level_o, rise_o, fall_o and event_cnt_o are 0. The FSM state is STABLE.
- Synchronizer: SYNC_STAGES-deep shift chain of raw_i. "sync" is the last stage.
- Debounce counter: width clog2(DEBOUNCE_CYCLES+1). Update on each edge:
  - If sync == level_o: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: level_o <= sync and counter <= 0.
  - Else: counter <= counter+1.
- FSM states:
  - STABLE (sync == level_o, counter 0).
  - PENDING (mismatch, counting).
  - STABLE->PENDING on the first mismatch edge.
  - PENDING->STABLE either on threshold (level_o flips) or on mismatch disappearing (abort: counter cleared, level_o unchanged).
- Latency: a raw_i change held stable reaches level_o exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples it. Defaults: 6 edges.
- Glitch rejection: a synchronized pulse shorter than DEBOUNCE_CYCLES cycles never changes level_o. With defaults, a 3-cycle raw pulse is rejected and a 4-cycle raw pulse is accepted.
- DEBOUNCE_CYCLES=1: level_o follows sync one edge later.
- rise_o/fall_o: registered, asserted for exactly the one cycle in which level_o first shows its new value. Never both high. Never high in consecutive cycles for the same direction.
- event_cnt_o:
  - Increments on the edge that sets rise_o.
  - Saturates at 2^CNT_W-1 and holds there; no wrap.
  - clr_i=1 clears it to 0 on the next edge.
  - If clr_i and a rise occur on the same edge, clear takes priority and the coincident rise is still counted: result 1.
  - Falling events never change it.
- Reset mid-operation:
  - All outputs return to 0 asynchronously, and any pending count is discarded.
  - If raw_i is 1 at reset release, a rise_o occurs SYNC_STAGES+DEBOUNCE_CYCLES edges after release.

Optional Feature:
INPUT_DEBOUNCER_GLITCH_CNT_EN
- Defined:
  - Adds output port glitch_cnt_o (input_debouncer output, 8 bits).
  - It counts every PENDING->STABLE abort (mismatch disappearing before threshold).
  - Saturates at 255.
  - Cleared by reset and by clr_i, with the same priority rule as event_cnt_o.
  - Threshold transitions are not counted.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Defaults; hold reset=0 with raw_i=1 -> level_o, rise_o, fall_o and event_cnt_o all 0. Release reset with raw_i held 1 -> level_o=1 and rise_o=1 for one cycle at the 6th edge after release; event_cnt_o=1.
2. From level_o=0, raw_i=1 for 3 cycles then 0 -> level_o stays 0, no rise_o, event_cnt_o unchanged (glitch_cnt_o=1 if enabled). Repeat with a 4-cycle pulse -> level_o=1 for 1 cycle-accurate window, rise_o then fall_o pulses.
3. level_o=1, drive raw_i=0 for 10 cycles -> fall_o one pulse 6 edges after change; level_o=0; event_cnt_o unchanged.
4. CNT_W=8; apply 260 clean pulses (each 10 cycles high, 10 low) -> event_cnt_o=255 and holds; clr_i for one cycle -> 0.
5. Assert clr_i on the exact edge rise_o is produced, with event_cnt_o=7 beforehand -> event_cnt_o=1.
6. Assert reset=0 while PENDING with counter=2 and level_o=1 -> level_o and event_cnt_o go to 0 before the next clk edge. No pulse outputs during reset.
